// File: rtl/tt_heartbeat_array.sv
// rtl/tt_heartbeat_array.sv - multi-channel heartbeat/pattern generator (off, blink, chase, breathe)
module tt_heartbeat_array #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 24,
  parameter int PWM_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] sig_A,
  output logic [CHANNELS-1:0] sig_OE,
  output logic                tick
);

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_BLINK   = 2'd1;
  localparam logic [1:0] MODE_CHASE   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  localparam logic [PWM_WIDTH-1:0] DMAX      = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CHANNELS-1:0]  CHASE_RST = {{(CHANNELS-1){1'b0}}, 1'b1};

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic [CHANNELS-1:0]  chase_q, chase_d;
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  logic                 dir_q, dir_d;
  logic [CHANNELS-1:0]  sig_a_q, sig_a_d;
  logic [CHANNELS-1:0]  sig_oe_q, sig_oe_d;
  logic                 tick_q, tick_d;

  logic                 wrap;
  logic                 mode_chg;
  logic [PWM_WIDTH-1:0] pwm_phase;
  logic [PWM_WIDTH-1:0] duty_inv;

  assign wrap      = en & (cnt_q == CNT_MAX);
  assign mode_chg  = (mode != mode_q);
  assign pwm_phase = cnt_q[PWM_WIDTH-1:0];
  assign duty_inv  = DMAX - duty_q;

  // Next-state: prescaler, pattern state (reinit beats advance), and the registered pad image
  always_comb begin
    cnt_d    = cnt_q;
    mode_d   = mode;
    chase_d  = chase_q;
    duty_d   = duty_q;
    dir_d    = dir_q;
    sig_a_d  = sig_a_q;
    sig_oe_d = '1;
    tick_d   = wrap;

    if (en) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (mode_chg) begin
      chase_d = CHASE_RST;
      duty_d  = '0;
      dir_d   = DIR_UP;
    end else if (wrap) begin
      chase_d = {chase_q[CHANNELS-2:0], chase_q[CHANNELS-1]};
      if (dir_q == DIR_UP) begin
        if (duty_q == DMAX) begin
          dir_d  = DIR_DOWN;
          duty_d = DMAX - 1'b1;
        end else begin
          duty_d = duty_q + 1'b1;
        end
      end else begin
        if (duty_q == '0) begin
          dir_d  = DIR_UP;
          duty_d = {{(PWM_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          duty_d = duty_q - 1'b1;
        end
      end
    end

    // Pads freeze while counting is disabled
    if (en) begin
      case (mode_q)
        MODE_OFF:   sig_a_d = '0;
        MODE_BLINK: sig_a_d = {CHANNELS{cnt_q[CNT_WIDTH-1]}};
        MODE_CHASE: sig_a_d = chase_q;
        MODE_BREATHE: begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (i % 2 == 0) sig_a_d[i] = (pwm_phase < duty_q);
            else            sig_a_d[i] = (pwm_phase < duty_inv);
          end
        end
        default:    sig_a_d = '0;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mode_q   <= MODE_OFF;
      chase_q  <= CHASE_RST;
      duty_q   <= '0;
      dir_q    <= DIR_UP;
      sig_a_q  <= '0;
      sig_oe_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      chase_q  <= chase_d;
      duty_q   <= duty_d;
      dir_q    <= dir_d;
      sig_a_q  <= sig_a_d;
      sig_oe_q <= sig_oe_d;
      tick_q   <= tick_d;
    end
  end

  assign sig_A  = sig_a_q;
  assign sig_OE = sig_oe_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_tt_heartbeat_array.sv
// tb/tb_tt_heartbeat_array.sv - scoreboard testbench for tt_heartbeat_array
module tb_tt_heartbeat_array;

  localparam int CH   = 4;
  localparam int CW   = 6;
  localparam int PW   = 3;
  localparam int CMAX = (1 << CW) - 1;
  localparam int DMX  = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [CH-1:0] sig_A;
  logic [CH-1:0] sig_OE;
  logic          tick;

  tt_heartbeat_array #(.CHANNELS(CH), .CNT_WIDTH(CW), .PWM_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sig_A(sig_A), .sig_OE(sig_OE), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] a;
    logic [CH-1:0] oe;
    logic          t;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: counter value, mode seen last edge, wraps since last reinit
  int m_cnt = 0;
  int m_modeq = 0;
  int m_wraps = 0;
  logic [CH-1:0] m_prev_a = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [CH-1:0] pattern(input int mq, input int c, input int w);
    logic [CH-1:0] r;
    int p, duty, lim;
    r = '0;
    case (mq)
      1: r = (c >= (1 << (CW - 1))) ? {CH{1'b1}} : '0;
      2: r[w % CH] = 1'b1;
      3: begin
        p    = w % (2 * DMX);
        duty = (p <= DMX) ? p : 2 * DMX - p;
        for (int i = 0; i < CH; i++) begin
          lim  = (i % 2 == 0) ? duty : DMX - duty;
          r[i] = ((c % (1 << PW)) < lim);
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic step(input logic r, input logic e, input logic [1:0] m);
    exp_t x;
    logic wrp;
    @(negedge clk);
    rst_n = r;
    en    = e;
    mode  = m;
    if (!r) begin
      x.a = '0; x.oe = '0; x.t = 1'b0;
      m_cnt = 0; m_modeq = 0; m_wraps = 0; m_prev_a = '0;
    end else begin
      wrp  = e && (m_cnt == CMAX);
      x.a  = e ? pattern(m_modeq, m_cnt, m_wraps) : m_prev_a;
      x.oe = {CH{1'b1}};
      x.t  = wrp;
      if (int'(m) != m_modeq) m_wraps = 0;
      else if (wrp)           m_wraps++;
      if (e) m_cnt = (m_cnt + 1) % (CMAX + 1);
      m_modeq  = int'(m);
      m_prev_a = x.a;
    end
    exp_q.push_back(x);
  endtask

  // Monitor: one expected record per clock edge, compared away from the edge
  always begin
    exp_t x;
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("sig_A",  32'(sig_A),  32'(x.a));
      chk("sig_OE", 32'(sig_OE), 32'(x.oe));
      chk("tick",   32'(tick),   32'(x.t));
    end
  end

  task automatic run(input int n, input logic e, input logic [1:0] m);
    for (int i = 0; i < n; i++) step(1'b1, e, m);
  endtask

  task automatic run_until_cnt(input int target, input logic [1:0] m);
    int n;
    n = 0;
    while (m_cnt != target && n < 200) begin
      step(1'b1, 1'b1, m);
      n++;
    end
    chk("cnt_wait_timeout", 32'(m_cnt == target), 32'd1);
  endtask

  initial begin
    int n;
    logic [1:0] rm;
    logic       re;

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'd0);

    run(200, 1'b1, 2'd1);
    run(300, 1'b1, 2'd2);
    run(10,  1'b1, 2'd0);
    run(140, 1'b1, 2'd2);

    n = 0;
    while ((m_wraps % CH) != 2 && n < 400) begin
      step(1'b1, 1'b1, 2'd2);
      n++;
    end
    chk("chase_wait_timeout", 32'((m_wraps % CH) == 2), 32'd1);
    run(3, 1'b1, 2'd2);
    run(100, 1'b0, 2'd2);
    run(140, 1'b1, 2'd2);

    run(1000, 1'b1, 2'd3);

    run_until_cnt(CMAX, 2'd3);
    step(1'b1, 1'b1, 2'd0);
    run(20, 1'b1, 2'd0);
    run_until_cnt(CMAX, 2'd2);
    step(1'b1, 1'b1, 2'd3);
    run(150, 1'b1, 2'd3);

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_sig_A",  32'(sig_A),  32'd0);
    chk("async_sig_OE", 32'(sig_OE), 32'd0);
    chk("async_tick",   32'(tick),   32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd2);

    rm = 2'd1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 59) == 0) rm = 2'($urandom_range(0, 3));
      re = ($urandom_range(0, 9) != 0);
      if (m_cnt == CMAX && re && $urandom_range(0, 3) == 0) rm = 2'($urandom_range(0, 3));
      step(1'b1, re, rm);
    end

    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #5;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
